// File: rtl/mmio_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O controller: CPU command
// encodings and the default I/O base addresses.
package mmio_ctrl_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'd0,
        MREAD  = 2'd1,
        MWRITE = 2'd2
    } mem_cmd_e;

    localparam logic [8:0] OUT_BASE_DEF = 9'h100;
    localparam logic [8:0] IN_BASE_DEF  = 9'h140;

endpackage

// File: rtl/mmio_ctrl_in_chan.sv
// One input channel: 2-flop synchroniser, previous-level flop and a sticky
// rising-edge register whose set term wins over a same-cycle clear.
module in_chan #(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] pin_i,
    input  logic [IN_W-1:0] clr_i,
    output logic [IN_W-1:0] lvl_o,
    output logic [IN_W-1:0] edge_o
);

    logic [IN_W-1:0] sync1_q;
    logic [IN_W-1:0] lvl_q;
    logic [IN_W-1:0] prev_q;
    logic [IN_W-1:0] edge_q;
    logic [IN_W-1:0] edge_d;

    assign edge_d = (edge_q & ~clr_i) | (lvl_q & ~prev_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            lvl_q   <= '0;
            prev_q  <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= pin_i;
            lvl_q   <= sync1_q;
            prev_q  <= lvl_q;
            edge_q  <= edge_d;
        end
    end

    assign lvl_o  = lvl_q;
    assign edge_o = edge_q;

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: RAM write gating, output registers, input
// channels with sticky edge capture, maskable irq and a registered read mux.
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 9,
    parameter int NUM_OUT = 2,
    parameter int OUT_W   = 8,
    parameter int NUM_IN  = 2,
    parameter int IN_W    = 8,
    parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(OUT_BASE_DEF),
    parameter logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(IN_BASE_DEF)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mem_cmd,
    input  logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W-1:0]         ram_dout,
    output logic                      ram_write,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_OUT*OUT_W-1:0]  out_ports,
    input  logic [NUM_IN*IN_W-1:0]    in_ports,
    output logic                      irq
);

    localparam logic [ADDR_W-1:0] MASK_ADDR = IN_BASE + ADDR_W'(2 * NUM_IN);

    logic               rd_en;
    logic               wr_en;
    logic               is_io;
    logic [OUT_W-1:0]   out_q [NUM_OUT];
    logic [OUT_W-1:0]   out_d [NUM_OUT];
    logic [NUM_IN-1:0]  mask_q;
    logic [NUM_IN-1:0]  mask_d;
    logic               irq_q;
    logic               irq_d;
    logic               rd_io_q;
    logic               rd_ram_q;
    logic [DATA_W-1:0]  io_q;
    logic [DATA_W-1:0]  io_rd_d;
    logic [IN_W-1:0]    lvl_w  [NUM_IN];
    logic [IN_W-1:0]    edge_w [NUM_IN];
    logic [IN_W-1:0]    clr_w  [NUM_IN];
    logic               unused_w;

    assign rd_en     = (mem_cmd == MREAD);
    assign wr_en     = (mem_cmd == MWRITE);
    assign is_io     = mem_addr[ADDR_W-1];
    assign ram_write = wr_en && !is_io;
    assign unused_w  = ^wdata;

    for (genvar j = 0; j < NUM_IN; j++) begin : g_in
        // Reading the edge-status word clears it at the same edge that latches it.
        assign clr_w[j] = {IN_W{rd_en && (mem_addr == IN_BASE + ADDR_W'(2 * j + 1))}};

        in_chan #(
            .IN_W(IN_W)
        ) u_in_chan (
            .clk   (clk),
            .reset (reset),
            .pin_i (in_ports[j*IN_W +: IN_W]),
            .clr_i (clr_w[j]),
            .lvl_o (lvl_w[j]),
            .edge_o(edge_w[j])
        );
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
        assign out_ports[i*OUT_W +: OUT_W] = out_q[i];
    end

    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        if (wr_en) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (mem_addr == OUT_BASE + ADDR_W'(i)) out_d[i] = wdata[OUT_W-1:0];
            end
            if (mem_addr == MASK_ADDR) mask_d = wdata[NUM_IN-1:0];
        end
    end

    always_comb begin
        io_rd_d = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (mem_addr == OUT_BASE + ADDR_W'(i)) io_rd_d = DATA_W'(out_q[i]);
        end
        for (int j = 0; j < NUM_IN; j++) begin
            if (mem_addr == IN_BASE + ADDR_W'(2 * j))     io_rd_d = DATA_W'(lvl_w[j]);
            if (mem_addr == IN_BASE + ADDR_W'(2 * j + 1)) io_rd_d = DATA_W'(edge_w[j]);
        end
        if (mem_addr == MASK_ADDR) io_rd_d = DATA_W'(mask_q);
    end

    always_comb begin
        irq_d = 1'b0;
        for (int j = 0; j < NUM_IN; j++) begin
            irq_d = irq_d | (mask_q[j] & (|edge_w[j]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
            rd_io_q  <= 1'b0;
            rd_ram_q <= 1'b0;
            io_q     <= '0;
        end else begin
            out_q    <= out_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
            rd_io_q  <= rd_en && is_io;
            rd_ram_q <= rd_en && !is_io;
            if (rd_en) io_q <= io_rd_d;
        end
    end

    // Source select is registered; RAM data arrives on its own one cycle later.
    assign rdata = rd_io_q  ? io_q     :
                   rd_ram_q ? ram_dout : '0;
    assign irq   = irq_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Scoreboard bench for mmio_ctrl: directed sequence from the test plan, then
// randomized traffic against a behavioural model of the register map.
module tb_mmio_ctrl;
    import mmio_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] wdata;
    logic [15:0] ram_dout;
    logic        ram_write;
    logic [15:0] rdata;
    logic [15:0] out_ports;
    logic [15:0] in_ports;
    logic        irq;

    mmio_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .mem_cmd  (mem_cmd),
        .mem_addr (mem_addr),
        .wdata    (wdata),
        .ram_dout (ram_dout),
        .ram_write(ram_write),
        .rdata    (rdata),
        .out_ports(out_ports),
        .in_ports (in_ports),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [15:0] ram_fn(input int c);
        return 16'(c * 40503) ^ 16'h1234;
    endfunction

    assign ram_dout = ram_fn(edge_cnt);

    typedef struct {
        int          due;
        logic [15:0] rd;
        logic        irq;
        logic [15:0] outp;
    } rec_t;

    rec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    logic [7:0]  out_m [2];
    logic [1:0]  mask_m;
    logic [15:0] edge_m;
    logic [15:0] hist [3];   // pin samples at the last three edges, newest first

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [15:0] io_read(input logic [8:0] a);
        logic [15:0] lvl;
        lvl = hist[1];
        case (a)
            9'h100:  return {8'h00, out_m[0]};
            9'h101:  return {8'h00, out_m[1]};
            9'h140:  return {8'h00, lvl[7:0]};
            9'h141:  return {8'h00, edge_m[7:0]};
            9'h142:  return {8'h00, lvl[15:8]};
            9'h143:  return {8'h00, edge_m[15:8]};
            9'h144:  return {14'h0, mask_m};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic step(input bit rst, input logic [1:0] cmd, input logic [8:0] addr,
                        input logic [15:0] wd, input logic [15:0] pins);
        rec_t        r;
        logic [15:0] lvl, prv, clr;
        reset    = rst;
        mem_cmd  = cmd;
        mem_addr = addr;
        wdata    = wd;
        in_ports = pins;
        #1;
        chk("ram_write", 32'(ram_write), 32'(cmd == MWRITE && !addr[8]));

        lvl = hist[1];
        prv = hist[2];
        r.due = edge_cnt + 1;
        r.rd  = 16'h0;
        r.irq = (mask_m[0] & (|edge_m[7:0])) | (mask_m[1] & (|edge_m[15:8]));
        if (rst) begin
            out_m[0] = 8'h0; out_m[1] = 8'h0;
            mask_m = 2'b0; edge_m = 16'h0;
            hist[0] = 16'h0; hist[1] = 16'h0; hist[2] = 16'h0;
            r.irq = 1'b0;
        end else begin
            clr = 16'h0;
            if (cmd == MREAD) begin
                r.rd = addr[8] ? io_read(addr) : ram_fn(edge_cnt + 1);
                if (addr == 9'h141) clr[7:0]  = 8'hFF;
                if (addr == 9'h143) clr[15:8] = 8'hFF;
            end
            if (cmd == MWRITE) begin
                if (addr == 9'h100) out_m[0] = wd[7:0];
                if (addr == 9'h101) out_m[1] = wd[7:0];
                if (addr == 9'h144) mask_m   = wd[1:0];
            end
            edge_m  = (edge_m & ~clr) | (lvl & ~prv);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = pins;
        end
        r.outp = {out_m[1], out_m[0]};
        sb.push_back(r);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == edge_cnt) begin
            rec_t r;
            r = sb.pop_front();
            chk("rdata", 32'(rdata), 32'(r.rd));
            chk("irq", 32'(irq), 32'(r.irq));
            chk("out_ports", 32'(out_ports), 32'(r.outp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] pins;
        logic [8:0]  alist [10];
        logic [1:0]  cmd;
        logic [8:0]  addr;
        alist = '{9'h100, 9'h101, 9'h102, 9'h140, 9'h141,
                  9'h142, 9'h143, 9'h144, 9'h145, 9'h1F0};

        // Reset with inputs held high, then edges appear after release
        step(1, MNONE, 9'h000, 16'h0, 16'hFFFF);
        step(1, MREAD, 9'h101, 16'h0, 16'hFFFF);
        repeat (3) step(0, MNONE, 9'h000, 16'h0, 16'hFFFF);
        step(0, MREAD, 9'h141, 16'h0, 16'hFFFF);
        step(0, MREAD, 9'h143, 16'h0, 16'hFFFF);

        // Output write/readback and RAM passthrough
        step(0, MWRITE, 9'h101, 16'hABCD, 16'hFFFF);
        step(0, MREAD,  9'h101, 16'h0,    16'hFFFF);
        step(0, MWRITE, 9'h020, 16'h5555, 16'hFFFF);
        step(0, MREAD,  9'h020, 16'h0,    16'hFFFF);

        // Edge capture with mask, then read-to-clear
        repeat (3) step(0, MNONE, 9'h000, 16'h0, 16'h0000);
        step(0, MWRITE, 9'h144, 16'h0001, 16'h0000);
        step(0, MNONE,  9'h000, 16'h0,    16'h0001);
        repeat (4) step(0, MNONE, 9'h000, 16'h0, 16'h0001);
        step(0, MREAD, 9'h141, 16'h0, 16'h0001);
        step(0, MREAD, 9'h141, 16'h0, 16'h0001);
        step(0, MNONE, 9'h000, 16'h0, 16'h0001);

        // Rising edge on bit 3 coincides with a clearing read
        step(0, MNONE, 9'h000, 16'h0, 16'h0009);
        step(0, MNONE, 9'h000, 16'h0, 16'h0009);
        step(0, MREAD, 9'h141, 16'h0, 16'h0009);
        step(0, MREAD, 9'h141, 16'h0, 16'h0009);

        // Ignored writes and unmapped read
        step(0, MWRITE, 9'h140, 16'hFFFF, 16'h0009);
        step(0, MWRITE, 9'h1F0, 16'hFFFF, 16'h0009);
        step(0, MREAD,  9'h1F0, 16'h0,    16'h0009);
        step(0, MREAD,  9'h100, 16'h0,    16'h0009);

        // Randomized traffic
        pins = 16'h0009;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) pins = pins ^ 16'($urandom);
            cmd = 2'($urandom_range(2));
            case ($urandom_range(9))
                0, 1:    addr = {1'b0, 8'($urandom)};
                2:       addr = {1'b1, 8'($urandom)};
                default: addr = alist[$urandom_range(9)];
            endcase
            step($urandom_range(96) == 0, cmd, addr, 16'($urandom), pins);
        end

        repeat (2) step(0, MNONE, 9'h000, 16'h0, pins);
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
